// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, addresses the program ROM, latches the word into the IR.
// Latency: 1 cycle from FETCH entry to instr_valid; at most one instruction per 2 cycles.
// Backpressure: instr_valid, opcode, operand, pc and rom_addr hold while instr_ready is low.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   run                     fetch enable, looked at in IDLE and on handshake cycles
//   rom_addr / rom_data     program ROM address (always pc) and combinational read data
//   instr_valid/instr_ready handshake towards the execute stage
//   opcode / operand        upper / lower halves of the instruction register
//   pc                      current program counter
//   jump_en / jump_addr     branch redirect, applied only on a handshake cycle
module fetch_unit #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_data,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [DATA_W/2-1:0] opcode,
  output logic [DATA_W/2-1:0] operand,
  output logic [ADDR_W-1:0]   pc,
  input  logic                jump_en,
  input  logic [ADDR_W-1:0]   jump_addr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              vld_q, vld_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    vld_d   = vld_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        // pc already points past the captured word while it sits in ISSUE;
        // the increment wraps naturally at 2^ADDR_W.
        ir_d    = rom_data;
        vld_d   = 1'b1;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (vld_q && instr_ready) begin
          vld_d   = 1'b0;
          // A redirect replaces the increment applied during FETCH.
          if (jump_en) pc_d = jump_addr;
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      vld_q   <= vld_d;
    end
  end

  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign instr_valid = vld_q;
  assign opcode      = ir_q[DATA_W-1:DATA_W/2];
  assign operand     = ir_q[DATA_W/2-1:0];

endmodule
